// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Purpose  : Shared encodings and the E-stage control bundle for the ARM
//            decode stage.
// Revision : 1.0
// ============================================================================
package arm_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP8   = 2'b00;
    localparam logic [1:0] IMM_MEM12 = 2'b01;
    localparam logic [1:0] IMM_BR24  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : r0..r14 storage, two read ports with r15 = PC+8 substitution and
//            same-cycle write bypass, one write port.
// Revision : 1.0
// ============================================================================
module reg_file #(
    parameter int NREGS = 15,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we_i,
    input  logic [3:0]    wa_i,
    input  logic [DW-1:0] wd_i,
    input  logic [3:0]    ra1_i,
    input  logic [3:0]    ra2_i,
    input  logic [DW-1:0] pc8_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o
);

    logic [DW-1:0] regs_q [NREGS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 4'hF)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // r15 wins over the bypass so a stray write to r15 never leaks into a read.
    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == 4'hF) begin
            rd1_o = pc8_i;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
    end

    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == 4'hF) begin
            rd2_o = pc8_i;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : ARM ID stage - main decoder, immediate extender, register file
//            and the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module decode_stage
    import arm_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   InstrD,
    input  logic [DW-1:0] PCPlus8D,
    input  logic          RegWriteW,
    input  logic [3:0]    WA3W,
    input  logic [DW-1:0] ResultW,
    input  logic          FlushE,
    output logic [3:0]    RA1D,
    output logic [3:0]    RA2D,
    output logic [DW-1:0] RD1E,
    output logic [DW-1:0] RD2E,
    output logic [DW-1:0] ExtImmE,
    output logic [3:0]    WA3E,
    output logic [3:0]    RA1E,
    output logic [3:0]    RA2E,
    output logic [3:0]    CondE,
    output logic          RegWriteE,
    output logic          MemWriteE,
    output logic          MemtoRegE,
    output logic          BranchE,
    output logic          ALUSrcE,
    output logic [1:0]    ALUControlE,
    output logic [1:0]    FlagWriteE
);

    logic [1:0]    op;
    logic [5:0]    funct;
    logic [3:0]    cmd;
    logic [1:0]    imm_src;
    ctrl_t         ctrl_d;
    logic [DW-1:0] ext_imm_d;
    logic [DW-1:0] rd1_d;
    logic [DW-1:0] rd2_d;

    ctrl_t         ctrl_q;
    logic [DW-1:0] rd1_q;
    logic [DW-1:0] rd2_q;
    logic [DW-1:0] ext_imm_q;
    logic [3:0]    wa3_q;
    logic [3:0]    ra1_q;
    logic [3:0]    ra2_q;
    logic [3:0]    cond_q;

    assign op    = InstrD[27:26];
    assign funct = InstrD[25:20];
    assign cmd   = funct[4:1];

    always_comb begin
        ctrl_d  = '0;
        imm_src = IMM_DP8;
        case (op)
            OP_DP: begin
                // Unsupported commands fall through as a bubble.
                if ((cmd == CMD_ADD) || (cmd == CMD_SUB) ||
                    (cmd == CMD_AND) || (cmd == CMD_ORR)) begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.alu_src    = funct[5];
                    ctrl_d.flag_write = {funct[0],
                                         funct[0] & ((cmd == CMD_ADD) || (cmd == CMD_SUB))};
                    case (cmd)
                        CMD_SUB: ctrl_d.alu_control = ALU_SUB;
                        CMD_AND: ctrl_d.alu_control = ALU_AND;
                        CMD_ORR: ctrl_d.alu_control = ALU_ORR;
                        default: ctrl_d.alu_control = ALU_ADD;
                    endcase
                end
            end
            OP_MEM: begin
                imm_src            = IMM_MEM12;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.reg_write   = funct[0];
                ctrl_d.mem_to_reg  = funct[0];
                ctrl_d.mem_write   = ~funct[0];
            end
            OP_BR: begin
                imm_src            = IMM_BR24;
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
    end

    always_comb begin
        case (imm_src)
            IMM_MEM12: ext_imm_d = {{(DW-12){1'b0}}, InstrD[11:0]};
            IMM_BR24:  ext_imm_d = {{(DW-26){InstrD[23]}}, InstrD[23:0], 2'b00};
            default:   ext_imm_d = {{(DW-8){1'b0}}, InstrD[7:0]};
        endcase
    end

    assign RA1D = (op == OP_BR) ? 4'hF : InstrD[19:16];
    assign RA2D = ((op == OP_MEM) && !funct[0]) ? InstrD[15:12] : InstrD[3:0];

    reg_file #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_reg_file (
        .CLK   (CLK),
        .RST   (RST),
        .we_i  (RegWriteW),
        .wa_i  (WA3W),
        .wd_i  (ResultW),
        .ra1_i (RA1D),
        .ra2_i (RA2D),
        .pc8_i (PCPlus8D),
        .rd1_o (rd1_d),
        .rd2_o (rd2_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST || FlushE) begin
            ctrl_q    <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ext_imm_q <= '0;
            wa3_q     <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            cond_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            ext_imm_q <= ext_imm_d;
            wa3_q     <= InstrD[15:12];
            ra1_q     <= RA1D;
            ra2_q     <= RA2D;
            cond_q    <= InstrD[31:28];
        end
    end

    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ExtImmE     = ext_imm_q;
    assign WA3E        = wa3_q;
    assign RA1E        = ra1_q;
    assign RA2E        = ra2_q;
    assign CondE       = cond_q;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign MemtoRegE   = ctrl_q.mem_to_reg;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign ALUControlE = ctrl_q.alu_control;
    assign FlagWriteE  = ctrl_q.flag_write;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage using directed instructions.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    // {RD1, RD2, ExtImm, WA3, RA1, RA2, Cond, RegW, MemW, MemtoReg, Branch, ALUSrc, ALUCtl, FlagW}
    typedef logic [120:0] vec_t;
    typedef struct packed {
        logic chk;
        vec_t v;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] InstrD = '0;
    logic [31:0] PCPlus8D = 32'h100;
    logic        RegWriteW = 1'b0;
    logic [3:0]  WA3W = '0;
    logic [31:0] ResultW = '0;
    logic        FlushE = 1'b0;
    logic [3:0]  RA1D, RA2D;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  WA3E, RA1E, RA2E, CondE;
    logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
    logic [1:0]  ALUControlE, FlagWriteE;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t sb_q[$];
    vec_t act;

    always #5 CLK = ~CLK;

    decode_stage dut (
        .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
        .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW), .FlushE(FlushE),
        .RA1D(RA1D), .RA2D(RA2D), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E), .CondE(CondE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .FlagWriteE(FlagWriteE)
    );

    assign act = {RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E, CondE,
                  RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE,
                  ALUControlE, FlagWriteE};

    function automatic vec_t ev(input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [3:0] wa3,
                                input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [3:0] cond, input logic [8:0] ctl);
        return {rd1, rd2, imm, wa3, ra1, ra2, cond, ctl};
    endfunction

    task automatic check(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one instruction plus W-port activity and queue the expected E state.
    task automatic cyc(input logic [31:0] instr, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic fl, input logic chk,
                       input vec_t v);
        @(negedge CLK);
        InstrD    = instr;
        RegWriteW = we;
        WA3W      = wa;
        ResultW   = wd;
        FlushE    = fl;
        sb_q.push_back('{chk: chk, v: v});
    endtask

    task automatic check_ra(input string name, input logic [3:0] e1, input logic [3:0] e2);
        #1;
        check(name, {113'd0, RA1D, RA2D}, {113'd0, e1, e2});
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) check("e_stage", act, e.v);
            end
        end
    end

    initial begin : stim
        repeat (3) @(negedge CLK);
        check("reset_state", act, '0);
        RST = 1'b0;

        cyc(32'h0,        1'b1, 4'd1,  32'h5,  1'b0, 1'b0, '0);
        cyc(32'h0,        1'b1, 4'd2,  32'h7,  1'b0, 1'b0, '0);
        cyc(32'hE0813002, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h5, 32'h7, 32'h2, 4'd3, 4'd1, 4'd2, 4'hE, 9'h100));
        check_ra("ra_add", 4'd1, 4'd2);
        cyc(32'hE0813002, 1'b1, 4'd1,  32'h55, 1'b0, 1'b1, ev(32'h55, 32'h7, 32'h2, 4'd3, 4'd1, 4'd2, 4'hE, 9'h100));
        cyc(32'hEAFFFFFE, 1'b1, 4'd15, 32'h99, 1'b0, 1'b1, ev(32'h100, 32'h0, 32'hFFFFFFF8, 4'hF, 4'hF, 4'hE, 4'hE, 9'h030));
        check_ra("ra_branch", 4'hF, 4'hE);
        cyc(32'hE5812004, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h55, 32'h7, 32'h4, 4'd2, 4'd1, 4'd2, 4'hE, 9'h090));
        check_ra("ra_store", 4'd1, 4'd2);
        cyc(32'hE5913008, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h55, 32'h0, 32'h8, 4'd3, 4'd1, 4'd8, 4'hE, 9'h150));
        cyc(32'hE0534001, 1'b1, 4'd4,  32'h44, 1'b1, 1'b1, '0);
        cyc(32'hE1945001, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h44, 32'h55, 32'h1, 4'd5, 4'd4, 4'd1, 4'hE, 9'h10E));
        cyc(32'hE0534001, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h0, 32'h55, 32'h1, 4'd4, 4'd3, 4'd1, 4'hE, 9'h107));
        cyc(32'hE281607F, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h55, 32'h100, 32'h7F, 4'd6, 4'd1, 4'hF, 4'hE, 9'h110));
        cyc(32'hE0223001, 1'b1, 4'd3,  32'h33, 1'b0, 1'b1, ev(32'h7, 32'h55, 32'h1, 4'd3, 4'd2, 4'd1, 4'hE, 9'h000));
        cyc(32'hEC123456, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h7, 32'h0, 32'h56, 4'd3, 4'd2, 4'd6, 4'hE, 9'h000));
        cyc(32'h10813002, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h55, 32'h7, 32'h2, 4'd3, 4'd1, 4'd2, 4'h1, 9'h100));
        cyc(32'hE0534001, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h33, 32'h55, 32'h1, 4'd4, 4'd3, 4'd1, 4'hE, 9'h107));

        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("async_reset", act, '0);
        @(negedge CLK);
        RST = 1'b0;
        cyc(32'hE0534001, 1'b0, 4'd0,  32'h0,  1'b0, 1'b1, ev(32'h0, 32'h0, 32'h1, 4'd4, 4'd3, 4'd1, 4'hE, 9'h107));

        repeat (3) @(negedge CLK);
        check("sb_drained", {89'd0, 32'(sb_q.size())}, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
